// File: rtl/bcd_time_pkg.sv
// rtl/bcd_time_pkg.sv - shared BCD timekeeping constants and helper functions
package bcd_time_pkg;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] NOON     = 8'h12;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // True when both nibbles hold a decimal digit.
  function automatic logic bcd_valid(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // BCD h + 12, used for 01..11 PM -> 13..23.
  function automatic logic [7:0] bcd_add12(input logic [7:0] h);
    logic [4:0] u;
    logic [3:0] t;
    u = {1'b0, h[3:0]} + 5'd2;
    t = h[7:4] + 4'd1;
    if (u > 5'd9) begin
      u = u - 5'd10;
      t = t + 4'd1;
    end
    return {t, u[3:0]};
  endfunction

  // BCD h - 12, used for 13..23 -> 01..11.
  function automatic logic [7:0] bcd_sub12(input logic [7:0] h);
    logic [3:0] u;
    logic [3:0] t;
    if (h[3:0] >= 4'd2) begin
      u = h[3:0] - 4'd2;
      t = h[7:4] - 4'd1;
    end else begin
      u = h[3:0] + 4'd8;
      t = h[7:4] - 4'd2;
    end
    return {t, u};
  endfunction

  // Next 24h BCD hour; 23 wraps to 00.
  function automatic logic [7:0] bcd_hour_inc(input logic [7:0] h);
    logic [7:0] n;
    if (h == HOUR_MAX) begin
      n = 8'h00;
    end else if (h[3:0] == 4'd9) begin
      n = {h[7:4] + 4'd1, 4'd0};
    end else begin
      n = {h[7:4], h[3:0] + 4'd1};
    end
    return n;
  endfunction

endpackage

// File: rtl/hour_fmt_conv.sv
// rtl/hour_fmt_conv.sv - combinational 24h hour to 24h/12h display conversion
module hour_fmt_conv
  import bcd_time_pkg::*;
(
  input  logic [7:0] h24,
  input  logic       mode_12h,
  output logic [7:0] q_out,
  output logic       pm
);

  // Map the stored 24h hour onto the selected display format.
  always_comb begin
    q_out = h24;
    pm    = 1'b0;
    if (mode_12h) begin
      if (h24 == 8'h00) begin
        q_out = NOON;
      end else if (h24 == NOON) begin
        pm    = 1'b1;
      end else if (h24 > NOON) begin
        q_out = bcd_sub12(h24);
        pm    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_hour24.sv
// rtl/bcd_hour24.sv - BCD hours counter with 24h/12h display, load validation and day carry
module bcd_hour24
  import bcd_time_pkg::*;
#(
  parameter logic [7:0] RESET_HOUR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       load,
  input  logic       load_pm,
  input  logic       c_in,
  input  logic       mode_12h,
  output logic [7:0] q_out,
  output logic       pm,
  output logic       c_out,
  output logic       load_err
);

  logic [7:0] h24_q, h24_d;
  logic       load_err_q, load_err_d;

  logic [7:0] load_h24;
  logic       load_ok;
  logic [7:0] chk_q;
  logic       chk_pm;

  // Candidate 24h value for a load, before validation.
  always_comb begin
    load_h24 = data;
    if (mode_12h) begin
      if (data == NOON) begin
        load_h24 = load_pm ? NOON : 8'h00;
      end else if (load_pm) begin
        load_h24 = bcd_add12(data);
      end
    end
  end

  // Converting the candidate back to 12h must reproduce the requested hour and AM/PM.
  hour_fmt_conv u_load_chk (
    .h24      (load_h24),
    .mode_12h (1'b1),
    .q_out    (chk_q),
    .pm       (chk_pm)
  );

  // Accept only legal BCD hours for the active format.
  always_comb begin
    load_ok = 1'b0;
    if (bcd_valid(data)) begin
      if (mode_12h) begin
        load_ok = (data >= 8'h01) && (data <= NOON) &&
                  (chk_q == data) && (chk_pm == load_pm);
      end else begin
        load_ok = (data <= HOUR_MAX);
      end
    end
  end

  // Next state: load beats c_in; a rejected load still swallows c_in.
  always_comb begin
    h24_d      = h24_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        h24_d = load_h24;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (c_in) begin
      h24_d = bcd_hour_inc(h24_q);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h24_q      <= RESET_HOUR;
      load_err_q <= 1'b0;
    end else begin
      h24_q      <= h24_d;
      load_err_q <= load_err_d;
    end
  end

  hour_fmt_conv u_disp (
    .h24      (h24_q),
    .mode_12h (mode_12h),
    .q_out    (q_out),
    .pm       (pm)
  );

  assign c_out    = c_in & ~load & (h24_q == HOUR_MAX);
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_hour24.sv
// tb/tb_bcd_hour24.sv - directed self-checking bench for bcd_hour24
module tb_bcd_hour24;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       load;
  logic       load_pm;
  logic       c_in;
  logic       mode_12h;
  logic [7:0] q_out;
  logic       pm;
  logic       c_out;
  logic       load_err;

  int vectors;
  int miscompares;

  bcd_hour24 #(.RESET_HOUR(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .load     (load),
    .load_pm  (load_pm),
    .c_in     (c_in),
    .mode_12h (mode_12h),
    .q_out    (q_out),
    .pm       (pm),
    .c_out    (c_out),
    .load_err (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] run24 [14];
  logic [7:0] run12 [10];
  logic [7:0] bad_data [4];
  logic       bad_mode [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    run24 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
              8'h17, 8'h18, 8'h19, 8'h20, 8'h21, 8'h22, 8'h23};
    run12 = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h07, 8'h08, 8'h09, 8'h10, 8'h11};
    bad_data = '{8'h24, 8'h1A, 8'h00, 8'h13};
    bad_mode = '{1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; data = 8'h00; load = 1'b0; load_pm = 1'b0;
    c_in = 1'b0; mode_12h = 1'b0;

    // Reset state, then mode toggle with no clock.
    #3;
    chk("rst_q", q_out, 8'h00);
    chk("rst_pm", {7'd0, pm}, 8'h00);
    chk("rst_cout", {7'd0, c_out}, 8'h00);
    chk("rst_lerr", {7'd0, load_err}, 8'h00);
    mode_12h = 1'b1;
    #1;
    chk("rst12_q", q_out, 8'h12);
    chk("rst12_pm", {7'd0, pm}, 8'h00);
    mode_12h = 1'b0;

    step();
    reset = 1'b0;

    // 24h load 09 then count up to 23 and wrap.
    load = 1'b1; data = 8'h09;
    step();
    load = 1'b0;
    chk("ld09_q", q_out, 8'h09);
    chk("ld09_lerr", {7'd0, load_err}, 8'h00);
    c_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("run24_q", q_out, run24[i]);
      chk("run24_cout", {7'd0, c_out}, (i == 13) ? 8'h01 : 8'h00);
    end
    step();
    c_in = 1'b0;
    chk("wrap_q", q_out, 8'h00);
    chk("wrap_lerr", {7'd0, load_err}, 8'h00);

    // 12h: 11 AM through noon, afternoon, midnight.
    mode_12h = 1'b1; load = 1'b1; data = 8'h11; load_pm = 1'b0;
    step();
    load = 1'b0;
    chk("ld11am_q", q_out, 8'h11);
    chk("ld11am_pm", {7'd0, pm}, 8'h00);
    c_in = 1'b1;
    step();
    chk("noon_q", q_out, 8'h12);
    chk("noon_pm", {7'd0, pm}, 8'h01);
    step();
    chk("1pm_q", q_out, 8'h01);
    chk("1pm_pm", {7'd0, pm}, 8'h01);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("run12_q", q_out, run12[i]);
      chk("run12_pm", {7'd0, pm}, 8'h01);
    end
    chk("11pm_cout", {7'd0, c_out}, 8'h01);
    step();
    c_in = 1'b0;
    chk("mid12_q", q_out, 8'h12);
    chk("mid12_pm", {7'd0, pm}, 8'h00);

    // 12h PM load and mode drop.
    load = 1'b1; data = 8'h07; load_pm = 1'b1;
    step();
    load = 1'b0; load_pm = 1'b0;
    chk("ld7pm_q", q_out, 8'h07);
    chk("ld7pm_pm", {7'd0, pm}, 8'h01);
    mode_12h = 1'b0;
    #1;
    chk("ld7pm24_q", q_out, 8'h19);
    chk("ld7pm24_pm", {7'd0, pm}, 8'h00);

    // 12 AM load stores midnight; 12 PM load stores noon.
    mode_12h = 1'b1; load = 1'b1; data = 8'h12; load_pm = 1'b0;
    step();
    load = 1'b0;
    chk("ld12am_pm", {7'd0, pm}, 8'h00);
    mode_12h = 1'b0;
    #1;
    chk("ld12am24_q", q_out, 8'h00);
    mode_12h = 1'b1; load = 1'b1; data = 8'h12; load_pm = 1'b1;
    step();
    load = 1'b0; load_pm = 1'b0; mode_12h = 1'b0;
    #1;
    chk("ld12pm24_q", q_out, 8'h12);

    // Rejected loads from 05.
    load = 1'b1; data = 8'h05;
    step();
    load = 1'b0;
    chk("ld05_q", q_out, 8'h05);
    for (int i = 0; i < 4; i++) begin
      mode_12h = bad_mode[i]; load = 1'b1; data = bad_data[i];
      step();
      load = 1'b0;
      chk("bad_q", q_out, 8'h05);
      chk("bad_lerr", {7'd0, load_err}, 8'h01);
      step();
      chk("bad_lerr_clr", {7'd0, load_err}, 8'h00);
      chk("bad_q_hold", q_out, 8'h05);
    end
    mode_12h = 1'b0;

    // Back-to-back bad loads keep load_err high.
    load = 1'b1; data = 8'h24;
    step();
    chk("b2b_lerr0", {7'd0, load_err}, 8'h01);
    data = 8'h3F;
    step();
    load = 1'b0;
    chk("b2b_lerr1", {7'd0, load_err}, 8'h01);
    step();
    chk("b2b_lerr_clr", {7'd0, load_err}, 8'h00);

    // Load at 23 with c_in suppresses carry.
    load = 1'b1; data = 8'h23;
    step();
    data = 8'h05; c_in = 1'b1;
    #1;
    chk("ldc_cout", {7'd0, c_out}, 8'h00);
    step();
    load = 1'b0;
    chk("ldc_q", q_out, 8'h05);
    chk("ldc_lerr", {7'd0, load_err}, 8'h00);
    step();
    chk("cnt06_q", q_out, 8'h06);

    // Bad load with c_in discards the increment, then async reset mid-cycle.
    load = 1'b1; data = 8'h24;
    step();
    load = 1'b0;
    chk("badc_q", q_out, 8'h06);
    chk("badc_lerr", {7'd0, load_err}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_q", q_out, 8'h00);
    chk("arst_lerr", {7'd0, load_err}, 8'h00);
    step();
    chk("arst_hold_q", q_out, 8'h00);
    c_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
